seg_display_driver: RTL and testbench
=====================================

// Module: seg_display_driver
// PURPOSE
//   Renders the board's 4-bit/N-bit counter values on a 4-digit common-anode 7-segment display.
//   - Accepts an unsigned binary value on a valid pulse.
//   - Converts it to BCD serially (shift-add-3), one bit per clock.
//   - Time-multiplexes the four digits at a divided scan rate.
//   - Sits downstream of counter logic, between it and the display pins.
// PARAMETERS
//   VAL_W     14     width of binary input; values above 9999 clamp
//   SCAN_DIV  50000  clk cycles each digit stays lit (>=2)
//   BLANK_LZ  1      1 = blank leading zeros (digit 0 always lit)
// PORTS
//   clk        in   1        system clock; all logic on posedge clk
//   rst        in   1        synchronous, active-high reset
//   din        in   VAL_W    unsigned binary value to display
//   din_valid  in   1        request; sampled only when busy==0
//   busy       out  1        conversion in progress
//   bcd        out  16       displayed value, 4 BCD nibbles, [15:12]=thousands
//   ovf        out  1        last accepted din exceeded 9999
//   an         out  4        digit enables, active-low, an[0]=units
//   seg        out  7        {g,f,e,d,c,b,a}, active-low
//   dp         out  1        decimal point, active-low
// BEHAVIOUR
//   Reset (rst==1 at posedge):
//     - an=4'b1111, seg=7'h7F, dp=1, busy=0, bcd=16'h0000, ovf=0.
//     - Scan index=0, divider=0, FSM=IDLE.
//     - Any conversion in progress is aborted.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE
//     - IDLE: on din_valid, load shift reg with min(din, 9999), set ovf=(din>9999), busy<=1 -> SHIFT.
//     - SHIFT: VAL_W cycles. Per cycle, add 3 to each BCD nibble >=5, then shift left one bit.
//     - DONE: bcd<=result, busy<=0 -> IDLE. Exactly one cycle.
//   Latency and timing:
//     - busy is high for VAL_W+1 cycles after the accepting edge.
//     - New bcd is visible on the same edge busy falls.
//   Handshake:
//     - din_valid while busy==1 is ignored (dropped, no queue).
//     - din_valid on the DONE edge is also ignored; it is accepted from the first cycle busy==0.
//   Clamping and width:
//     - Comparison is done at full VAL_W width.
//     - ovf holds until the next accepted value.
//   Display:
//     - Display reads bcd only; intermediate shift state is never shown.
//   Scan:
//     - Divider counts 0..SCAN_DIV-1 continuously; conversion does not stall it.
//     - At terminal count the scan index increments mod 4 (3->0 wraps).
//     - an, seg and dp are registered and update one cycle after the index changes.
//     - an is one-hot low on the indexed digit.
//   Digit encoding (hex, active-low):
//     0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
//     Nibbles >9 cannot occur; if forced, show 7F.
//   Leading-zero blanking (BLANK_LZ=1):
//     - A digit shows 7F (an still driven) if it and all higher digits are zero.
//     - Digit 0 is never blanked.
//   Decimal point: dp=0 only on digit 3 while ovf==1; otherwise dp=1.
// TESTING  (bench uses SCAN_DIV=4, VAL_W=14)
//   1. Reset, release, run 1 scan cycle
//      -> an=1111/seg=7F during reset.
//      -> After release: digit0 an=1110 seg=40; digits 1-3 seg=7F.
//   2. din=1234, one-cycle valid
//      -> busy high exactly 15 cycles; bcd=16'h1234, ovf=0.
//      -> Scan shows 79,24,30,19 on an=0111,1011,1101,1110.
//   3. din=16383 -> bcd=16'h9999, ovf=1; dp=0 only while an=0111.
//   4. din=7, BLANK_LZ=1
//      -> digit0 seg=78; digits 1-3 seg=7F.
//      -> Same with BLANK_LZ=0: digits 1-3 seg=40.
//   5. din=42 accepted, then din=99 valid 3 cycles later (busy=1) -> bcd=16'h0042; 99 discarded.
//   6. din=5000 accepted, rst pulsed 5 cycles later -> all reset values next edge; bcd stays 0 after.

Source files
------------

// File: rtl/seg_display_driver.sv
// Binary-to-BCD (serial shift-add-3) converter driving a multiplexed
// 4-digit common-anode 7-segment display with optional leading-zero blanking.
module seg_display_driver #(
    parameter int unsigned VAL_W    = 14,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] din,
    input  logic             din_valid,
    output logic             busy,
    output logic [15:0]      bcd,
    output logic             ovf,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);
    localparam int unsigned CW    = $clog2(VAL_W + 1);
    localparam int unsigned CMP_W = (VAL_W > 14) ? VAL_W : 14;
    localparam int unsigned DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic [CW-1:0]     cnt;
    logic [VAL_W-1:0]  bin;
    logic [15:0]       work, adj;
    logic [CMP_W-1:0]  din_ext;
    logic              over;

    assign din_ext = CMP_W'(din);
    assign over    = din_ext > CMP_W'(9999);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(VAL_W - 1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adj = work;
        for (int unsigned i = 0; i < 4; i++) begin
            if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
            work  <= '0;
            bin   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bin  <= over ? VAL_W'(9999) : din;
                ovf  <= over;
                work <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (state == SHIFT) begin
                work <= {adj[14:0], bin[VAL_W-1]};
                bin  <= bin << 1;
                cnt  <= cnt + CW'(1);
            end else if (state == DONE) begin
                bcd  <= work;
                busy <= 1'b0;
            end
        end
    end

    // Scan divider free-runs; conversion activity never stalls it.
    logic [DW-1:0] div;
    logic [1:0]    idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + DW'(1);
        end
    end

    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_nxt;
    logic [3:0] an_nxt;
    logic       dp_nxt;

    always_comb begin
        digit = 4'(bcd >> {idx, 2'b00});
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (bcd[15:4] == 12'h000);
            2'd2:    blank = (bcd[15:8] == 8'h00);
            2'd3:    blank = (bcd[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        if (BLANK_LZ == 0) blank = 1'b0;

        case (digit)
            4'd0:    seg_nxt = 7'h40;
            4'd1:    seg_nxt = 7'h79;
            4'd2:    seg_nxt = 7'h24;
            4'd3:    seg_nxt = 7'h30;
            4'd4:    seg_nxt = 7'h19;
            4'd5:    seg_nxt = 7'h12;
            4'd6:    seg_nxt = 7'h02;
            4'd7:    seg_nxt = 7'h78;
            4'd8:    seg_nxt = 7'h00;
            4'd9:    seg_nxt = 7'h10;
            default: seg_nxt = 7'h7F;
        endcase
        if (blank) seg_nxt = 7'h7F;

        an_nxt = ~(4'b0001 << idx);
        dp_nxt = !((idx == 2'd3) && ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end
endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: stimulus pushes expected conversion
// results, a monitor pops them when busy falls; scan output checked directly.
module tb_seg_display_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] din = '0;
    logic        din_valid = 1'b0;

    logic        busy, ovf, dp;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    logic        busy2, ovf2, dp2;
    logic [15:0] bcd2;
    logic [3:0]  an2;
    logic [6:0]  seg2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    seg_display_driver #(.VAL_W(14), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .busy(busy), .bcd(bcd), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
    );

    seg_display_driver #(.VAL_W(14), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .busy(busy2), .bcd(bcd2), .ovf(ovf2), .an(an2), .seg(seg2), .dp(dp2)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each active edge.
    logic prev_busy = 1'b0;
    int   busy_cnt  = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got bcd %h with no pending request", bcd);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result_bcd", bcd, e.bcd);
                    chk("result_bcd_nb", bcd2, e.bcd);
                    chk("result_ovf", 16'(ovf), 16'(e.ovf));
                    chk("busy_cycles", 16'(busy_cnt), 16'd15);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy %b expected 0 within 100 cycles", busy);
        end
    endtask

    task automatic send(input logic [13:0] v, input logic [15:0] eb, input logic eo, input bit push);
        exp_t e;
        wait_idle();
        din       = v;
        din_valid = 1'b1;
        if (push) begin
            e.bcd = eb;
            e.ovf = eo;
            q.push_back(e);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic settle();
        wait_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_digit(input int k, input logic [6:0] s1, input logic [6:0] s2, input logic dpe);
        logic [3:0] target;
        int n;
        target = ~(4'b0001 << k);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (an == target) break;
        end
        if (n == 40) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout: an %b never reached %b", an, target);
        end else begin
            chk($sformatf("seg_d%0d", k), 16'(seg), 16'(s1));
            chk($sformatf("seg_nb_d%0d", k), 16'(seg2), 16'(s2));
            chk($sformatf("dp_d%0d", k), 16'(dp), 16'(dpe));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset state and first digit after release
        repeat (3) @(negedge clk);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_ovf", 16'(ovf), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_an", 16'(an), 16'hE);
        chk("first_seg", 16'(seg), 16'h40);
        for (int k = 1; k < 4; k++) check_digit(k, 7'h7F, 7'h40, 1'b1);
        check_digit(0, 7'h40, 7'h40, 1'b1);

        // 2. 1234
        send(14'd1234, 16'h1234, 1'b0, 1'b1);
        settle();
        check_digit(3, 7'h79, 7'h79, 1'b1);
        check_digit(2, 7'h24, 7'h24, 1'b1);
        check_digit(1, 7'h30, 7'h30, 1'b1);
        check_digit(0, 7'h19, 7'h19, 1'b1);

        // 3. clamp
        send(14'd16383, 16'h9999, 1'b1, 1'b1);
        settle();
        check_digit(3, 7'h10, 7'h10, 1'b0);
        check_digit(0, 7'h10, 7'h10, 1'b1);
        check_digit(2, 7'h10, 7'h10, 1'b1);

        // 4. 7 with and without blanking
        send(14'd7, 16'h0007, 1'b0, 1'b1);
        settle();
        check_digit(0, 7'h78, 7'h78, 1'b1);
        for (int k = 1; k < 4; k++) check_digit(k, 7'h7F, 7'h40, 1'b1);

        // 5. request during busy is dropped
        send(14'd42, 16'h0042, 1'b0, 1'b1);
        @(negedge clk);
        din       = 14'd99;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        settle();
        chk("drop_bcd", bcd, 16'h0042);
        check_digit(1, 7'h19, 7'h19, 1'b1);
        check_digit(2, 7'h7F, 7'h40, 1'b1);

        // 5b. valid held through DONE is taken on the first idle cycle
        begin
            exp_t e;
            int n;
            wait_idle();
            din       = 14'd300;
            din_valid = 1'b1;
            e.bcd = 16'h0300; e.ovf = 1'b0; q.push_back(e);
            @(negedge clk);
            din = 14'd99;
            e.bcd = 16'h0099; e.ovf = 1'b0; q.push_back(e);
            for (n = 0; n < 40; n++) begin
                @(negedge clk);
                if (!busy) break;
            end
            if (n == 40) begin
                checks++;
                failures++;
                $display("FAIL held_timeout: busy %b expected 0", busy);
            end
            @(negedge clk);
            chk("held_accept_busy", 16'(busy), 16'h1);
            din_valid = 1'b0;
            settle();
        end

        // 6. reset aborts a conversion
        send(14'd5000, 16'h5000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_an", 16'(an), 16'hF);
        chk("abort_seg", 16'(seg), 16'h7F);
        chk("abort_dp", 16'(dp), 16'h1);
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_bcd", bcd, 16'h0000);
        chk("abort_ovf", 16'(ovf), 16'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("after_abort_bcd", bcd, 16'h0000);
        chk("after_abort_busy", 16'(busy), 16'h0);
        chk("queue_empty", 16'(q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
